// File: rtl/decoder3_8_stream_pkg.sv
// dec_pkg: shared widths, buffer-state enum and the en-gated one-hot decode
package dec_pkg;
    localparam int CODE_W = 3;
    localparam int Y_W = 8;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
    function automatic logic [Y_W-1:0] decode_onehot(input logic en, input logic [CODE_W-1:0] code);
        return en ? ({{(Y_W-1){1'b0}}, 1'b1} << code) : '0;
    endfunction
endpackage

// File: rtl/decoder3_8_stream_if.sv
// decoder3_8_stream_if: code-in / one-hot-out valid-ready bundle
interface decoder3_8_stream_if;
    import dec_pkg::*;
    logic              en;
    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;
    logic [Y_W-1:0]    out_y;
    logic              out_valid;
    logic              out_ready;
    modport master (output en, in_code, in_valid, out_ready, input in_ready, out_y, out_valid);
    modport slave  (input en, in_code, in_valid, out_ready, output in_ready, out_y, out_valid);
endinterface

// File: rtl/decoder3_8_stream_comb.sv
// decoder3_8_comb: combinational en-gated 3-to-8 one-hot decode
module decoder3_8_comb
    import dec_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [Y_W-1:0]    y
);
    assign y = decode_onehot(en, code);
endmodule

// File: rtl/decoder3_8_stream.sv
// decoder3_8_stream: registered 3-to-8 decoder behind a 2-entry skid buffer with transfer counter
module decoder3_8_stream
    import dec_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder3_8_stream_if.slave   bus,
    output logic [CNT_W-1:0]     xfer_cnt
);
    state_e         state, state_nxt;
    logic [Y_W-1:0] head, tail, dec_y;
    logic           push, pop;

    decoder3_8_comb u_dec (.en(bus.en), .code(bus.in_code), .y(dec_y));

    assign push      = bus.in_valid & bus.in_ready;
    assign pop       = bus.out_valid & bus.out_ready;
    assign bus.out_y = head;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;

    // occupancy transitions; FULL never sees a push, EMPTY never sees a pop
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = push ? ONE : EMPTY;
            ONE:     state_nxt = (push && !pop) ? FULL : ((pop && !push) ? EMPTY : ONE);
            FULL:    state_nxt = pop ? ONE : FULL;
            default: state_nxt = EMPTY;
        endcase
    end

    // handshake outputs depend on registered state only
    always_comb begin
        bus.in_ready  = (state != FULL);
        bus.out_valid = (state != EMPTY);
    end

    // head is what the consumer sees; it zeroes when the buffer drains
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= pop ? ((state == FULL) ? tail : (push ? dec_y : '0))
                        : ((push && state == EMPTY) ? dec_y : head);
            tail <= (push && !pop && state == ONE) ? dec_y
                        : ((pop && state == FULL) ? '0 : tail);
        end

    // completed output transfers, wrapping
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + 1'b1;
endmodule

// File: tb/tb_decoder3_8_stream.sv
// tb_decoder3_8_stream: directed-vector check of decoder3_8_stream
module tb_decoder3_8_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int         checks = 0;
    int         failures = 0;

    decoder3_8_stream_if b();
    decoder3_8_stream_if b2();

    assign b2.en        = b.en;
    assign b2.in_code   = b.in_code;
    assign b2.in_valid  = b.in_valid;
    assign b2.out_ready = b.out_ready;

    decoder3_8_stream #(.CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(b),  .xfer_cnt(cnt));
    decoder3_8_stream #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .xfer_cnt(cnt2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.en = 1'b0; b.in_code = '0; b.in_valid = 1'b0; b.out_ready = 1'b0;
        #2;
        chk("rst_valid", b.out_valid, 0);
        chk("rst_y", b.out_y, 8'h00);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", b.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // sweep codes 0..7, one per cycle; narrow counter wraps 1,2,3,0,1
        b.out_ready = 1'b1; b.in_valid = 1'b1; b.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b.in_code = 3'(i);
            cyc();
            chk($sformatf("sweep_y%0d", i), b.out_y, 32'h1 << i);
            chk($sformatf("sweep_v%0d", i), b.out_valid, 1);
            chk($sformatf("sweep_rdy%0d", i), b.in_ready, 1);
            chk($sformatf("sweep_cnt%0d", i), cnt, i);
            chk($sformatf("wrap_cnt%0d", i), cnt2, i % 4);
        end
        b.in_valid = 1'b0;
        cyc();
        chk("sweep_drain_v", b.out_valid, 0);
        chk("sweep_drain_y", b.out_y, 8'h00);
        chk("sweep_cnt_end", cnt, 8);

        // enable gating
        b.in_valid = 1'b1; b.en = 1'b0; b.in_code = 3'd5;
        cyc();
        chk("en0_y", b.out_y, 8'h00);
        chk("en0_v", b.out_valid, 1);
        b.en = 1'b1;
        cyc();
        chk("en1_y", b.out_y, 8'h20);
        chk("en1_cnt", cnt, 9);
        b.in_valid = 1'b0;
        cyc();
        chk("en_cnt", cnt, 10);
        chk("en_cnt2", cnt2, 2);

        // backpressure
        b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_code = 3'd3;
        cyc();
        chk("bp_y1", b.out_y, 8'h08);
        chk("bp_rdy1", b.in_ready, 1);
        b.in_code = 3'd6;
        cyc();
        chk("bp_rdy2", b.in_ready, 0);
        chk("bp_y2", b.out_y, 8'h08);
        b.in_code = 3'd2;
        cyc();
        b.in_code = 3'd1;
        cyc();
        chk("bp_hold_y", b.out_y, 8'h08);
        chk("bp_hold_v", b.out_valid, 1);
        chk("bp_hold_rdy", b.in_ready, 0);
        chk("bp_hold_cnt", cnt, 10);
        b.out_ready = 1'b1;
        cyc();
        chk("bp_pop1_y", b.out_y, 8'h40);
        chk("bp_pop1_rdy", b.in_ready, 1);
        cyc();
        chk("bp_pop2_y", b.out_y, 8'h02);
        chk("bp_pop2_cnt", cnt, 12);
        b.in_valid = 1'b0;
        cyc();
        chk("bp_end_v", b.out_valid, 0);
        chk("bp_end_cnt", cnt, 13);

        // simultaneous push and pop while holding one word
        b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_code = 3'd2;
        cyc();
        chk("pp_hold_y", b.out_y, 8'h04);
        b.in_code = 3'd7; b.out_ready = 1'b1;
        cyc();
        chk("pp_y", b.out_y, 8'h80);
        chk("pp_v", b.out_valid, 1);
        chk("pp_rdy", b.in_ready, 1);
        chk("pp_cnt", cnt, 14);
        b.in_valid = 1'b0;
        cyc();
        chk("pp_end_v", b.out_valid, 0);
        chk("pp_end_cnt", cnt, 15);

        // asynchronous reset while full
        b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_code = 3'd0;
        cyc();
        b.in_code = 3'd1;
        cyc();
        b.in_valid = 1'b0;
        chk("ar_full_rdy", b.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_v", b.out_valid, 0);
        chk("ar_y", b.out_y, 8'h00);
        chk("ar_cnt", cnt, 0);
        chk("ar_cnt2", cnt2, 0);
        chk("ar_rdy", b.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        b.out_ready = 1'b1; b.in_valid = 1'b1; b.en = 1'b1; b.in_code = 3'd4;
        cyc();
        chk("ar_post_y", b.out_y, 8'h10);
        chk("ar_post_v", b.out_valid, 1);
        b.in_valid = 1'b0;
        cyc();
        chk("ar_post_cnt", cnt, 1);
        chk("ar_post_end_v", b.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decoder3_8_stream.md
Name: decoder3_8_stream

Overview:
- Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides. It is the inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code plus enable and emits the matching one-hot 8-bit word through a 2-entry skid buffer.
- Counts completed output transfers.
- Sits between a code producer (e.g. the encoder output path) and one-hot consumers such as line selects or LED drivers.

Parameters:
CNT_W, 8, width of the output-transfer counter xfer_cnt (wraps modulo 2^CNT_W)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
en  input  1  decode enable, sampled with the code on input transfer; 0 forces a zero output word
in_code  input  3  code to decode; bit 2 is MSB (A2), bit 0 is LSB (A0)
in_valid  input  1  producer has a code on in_code/en
in_ready  output  1  block can accept a code this cycle
out_y  output  8  decoded word; bit k corresponds to line Yk
out_valid  output  1  out_y holds a valid word
out_ready  input  1  consumer accepts out_y this cycle
xfer_cnt  output  CNT_W  number of completed output transfers, wrapping

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty; state EMPTY; out_valid=0; out_y=8'h00; xfer_cnt=0; in_ready=1. Both buffer entries clear to 8'h00.
- Input transfer: in_valid & in_ready at a rising edge. The stored word is (en ? (8'h01 << in_code) : 8'h00), so decoding happens at accept time.
- Output transfer: out_valid & out_ready at a rising edge.
- Buffer FSM, count = number of held words:
  - EMPTY: push -> ONE.
  - ONE: push & pop -> ONE; push only -> FULL; pop only -> EMPTY; neither -> ONE.
  - FULL: pop -> ONE; no push is possible.
- in_ready = (state != FULL). It depends only on registered state, never combinationally on out_ready.
- out_valid = (state != EMPTY). out_y = head entry, registered, with no combinational path from in_code.
- When the buffer is empty, out_y = 8'h00.
- Latency: a code accepted at edge N appears on out_y/out_valid after edge N, with the buffer previously empty.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, two words are accepted, then in_ready drops. When out_ready rises, the head pops first and order is preserved (FIFO).
- Simultaneous push & pop in ONE: the head is replaced by the incoming word in the same edge; there is no bubble and no duplication.
- out_y is a stable hold: while out_valid=1 and out_ready=0, out_y and out_valid must not change.
- en=0 entries are real transfers. They occupy a slot, emit 8'h00 with out_valid=1, and increment xfer_cnt.
- in_code values are always legal (all 8 map to a line), so there is no error path.
- xfer_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all held words are dropped immediately, outputs return to reset values asynchronously, and operation resumes normally on the first edge after rst_n deasserts.
- in_valid may be held high with a changing code while in_ready=0. Nothing is captured until in_ready=1.

Decomposition:
- Shared package dec_pkg contains:
  - constants CODE_W=3 and Y_W=8;
  - the buffer-state enum {EMPTY, ONE, FULL};
  - the en-gated one-hot decode function.
- One sub-module, decoder3_8_comb: purely combinational, with inputs en and code[2:0] and output y[7:0]. It is instantiated once at the input side.
- Buffer, FSM and counter live in decoder3_8_stream.

Test Plan:
1. Post-reset sweep: hold out_ready=1; feed codes 0..7 with en=1 on consecutive cycles. Required: out_y = 01,02,04,08,10,20,40,80 on consecutive cycles, each one cycle after accept; xfer_cnt ends at 8; in_ready stays 1.
2. Enable gating: send code 5 with en=0, then code 5 with en=1. Required: out_y=8'h00 with out_valid=1, then 8'h20; xfer_cnt increments by 2.
3. Backpressure: hold out_ready=0; offer codes 3, 6, 1. Required: 3 and 6 accepted; in_ready=0 after the second accept; code 1 held off; out_y stays 8'h08 and stable. Release out_ready: output order 08, 40, 02.
4. Simultaneous push/pop in ONE: with one word (code 2) held, assert in_valid with code 7 and out_ready=1 in the same cycle. Required: next cycle out_y=8'h80, state ONE, no gap or repeat.
5. Counter wrap (CNT_W=2): complete 5 output transfers. Required: xfer_cnt sequence 1,2,3,0,1.
6. Async reset mid-operation: with FULL and out_ready=0, pull rst_n low between edges. Required: immediately out_valid=0, out_y=00, xfer_cnt=0, in_ready=1. After release, code 4 decodes to 8'h10 with one-cycle latency.
